// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the nibble-serial signed adder/subtractor.
// Holds the FSM state encoding, the nibble width and the counter-width helper.
package addsub_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes every nibble of a WIDTH-bit operand (at least 1 bit).
    function automatic int nib_count(input int width);
        int nibbles;
        nibbles = width / NIB_W;
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/addsub_seq_16bit_nibble_adder.sv
// Combinational 4-bit ripple-carry adder used once per clock by the serial add/sub.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module nibble_adder
    import addsub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout  = w_c[NIB_W];
    assign o_c_msb = w_c[NIB_W-1];

endmodule

// File: rtl/addsub_seq_16bit.sv
// Multi-cycle signed add/sub: one nibble per clock, carry held in a register, Z/V/N flags.
// Optional macro ADDSUB_SATURATE_EN clamps the result on signed overflow.
module addsub_seq_16bit
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             busy
);

    localparam int                NIBBLES  = WIDTH / NIB_W;
    localparam int                CNT_W    = nib_count(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam logic [WIDTH-1:0]  SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_z;
    logic             r_v;
    logic             r_n;

    logic [NIB_W-1:0] w_a_nib [NIBBLES];
    logic [NIB_W-1:0] w_b_nib [NIBBLES];
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_v;
    logic             w_last;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_final;

    // Split operands into nibbles and splice the fresh sum into the selected result slot.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[gi*NIB_W +: NIB_W];
            assign w_b_nib[gi] = r_b[gi*NIB_W +: NIB_W];
            assign w_merged[gi*NIB_W +: NIB_W] =
                (r_cnt == CNT_W'(gi)) ? w_sum : r_result[gi*NIB_W +: NIB_W];
        end
    endgenerate

    nibble_adder u_nibble_adder (
        .i_a     (w_a_nib[r_cnt]),
        .i_b     (w_b_nib[r_cnt]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    assign w_last = (r_cnt == LAST_CNT);
    assign w_v    = w_c_msb ^ w_cout;

`ifdef ADDSUB_SATURATE_EN
    // The sign of A decides the clamp direction, since overflow only occurs when A and B_eff agree in sign.
    assign w_final = w_v ? (r_a[WIDTH-1] ? SAT_NEG : SAT_POS) : w_merged;
`else
    assign w_final = w_merged;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_final;
                        r_z      <= (w_final == '0);
                        r_v      <= w_v;
                        r_n      <= w_final[WIDTH-1];
                        r_state  <= DONE;
                    end else begin
                        r_result <= w_merged;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_v    = r_v;
    assign flag_n    = r_n;

endmodule

// File: tb/tb_addsub_seq_16bit.sv
// Self-checking bench for addsub_seq_16bit: directed literal cases plus randomized ops
// compared every cycle against an integer-arithmetic reference model.
module tb_addsub_seq_16bit;

    localparam int NIB = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        busy;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    int total = 0;
    int bad   = 0;

    addsub_seq_16bit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact signed integer arithmetic, then wrap or clamp to 16 bits.
    function automatic exp_t model_op(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t        e;
        int          sx;
        int          sy;
        int          r;
        logic [31:0] ru;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? (sx - sy) : (sx + sy);
        ru = r;
        e.v   = (r > 32767) || (r < -32768);
        e.res = ru[15:0];
`ifdef ADDSUB_SATURATE_EN
        if (e.v) e.res = (sx >= 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    // Timing model: idle -> NIB busy cycles -> done until consumed; reset drops everything.
    int   m_phase     = 0;  // 0 idle, 1 computing, 2 result available
    int   m_left      = 0;
    logic m_after_rst = 1'b0;
    logic chk_en      = 1'b0;
    exp_t m_pend;
    exp_t m_exp;

    always @(posedge clk) begin
        if (rst) begin
            m_phase     = 0;
            m_left      = 0;
            m_after_rst = 1'b1;
            chk_en      = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend      = model_op(a, b, sub);
                    m_left      = NIB;
                    m_phase     = 1;
                    m_after_rst = 1'b0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_exp   = m_pend;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, m_phase == 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            chk("busy",      {31'd0, busy},      {31'd0, m_phase != 0});
            if (m_phase == 2) begin
                chk("result", {16'd0, result}, {16'd0, m_exp.res});
                chk("flags",  {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_exp.z, m_exp.v, m_exp.n});
            end
            if (m_after_rst && m_phase == 0) begin
                chk("rst_result", {16'd0, result}, 32'd0);
                chk("rst_flags",  {29'd0, flag_z, flag_v, flag_n}, 32'd0);
            end
        end
    end

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input int hold, output exp_t got, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a = x; b = y; sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
        got = {result, flag_z, flag_v, flag_n};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid",  {31'd0, out_valid}, 32'd1);
            chk("hold_ready",  {31'd0, in_ready},  32'd0);
            chk("hold_result", {13'd0, result, flag_z, flag_v, flag_n}, {13'd0, got});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_idle", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        got;
        int          lat;
        logic [15:0] rx;
        logic [15:0] ry;
        logic        rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op(16'h00FF, 16'h0001, 1'b0, 0, got, lat);
        chk("t1_result", {16'd0, got.res}, 32'h0100);
        chk("t1_zvn", {29'd0, got.z, got.v, got.n}, 32'd0);
        chk("t1_latency", lat, 32'd4);

        do_op(16'h0005, 16'h0005, 1'b1, 0, got, lat);
        chk("t2_result", {16'd0, got.res}, 32'h0000);
        chk("t2_zvn", {29'd0, got.z, got.v, got.n}, 32'b100);

        do_op(16'h7FFF, 16'h0001, 1'b0, 0, got, lat);
`ifdef ADDSUB_SATURATE_EN
        chk("t3_result", {16'd0, got.res}, 32'h7FFF);
        chk("t3_zvn", {29'd0, got.z, got.v, got.n}, 32'b010);
`else
        chk("t3_result", {16'd0, got.res}, 32'h8000);
        chk("t3_zvn", {29'd0, got.z, got.v, got.n}, 32'b011);
`endif

        do_op(16'h8000, 16'h0001, 1'b1, 3, got, lat);
`ifdef ADDSUB_SATURATE_EN
        chk("t4_result", {16'd0, got.res}, 32'h8000);
        chk("t4_zvn", {29'd0, got.z, got.v, got.n}, 32'b011);
`else
        chk("t4_result", {16'd0, got.res}, 32'h7FFF);
        chk("t4_zvn", {29'd0, got.z, got.v, got.n}, 32'b010);
`endif

        // Reset in the middle of a computation, then a clean op afterwards.
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_idle", {31'd0, in_ready}, 32'd1);
        chk("t6_result", {16'd0, result}, 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, got, lat);
        chk("t6_after", {16'd0, got.res}, 32'h0002);

        for (int i = 0; i < 150; i++) begin
            exp_t want;
            case ($urandom_range(0, 5))
                0:       rx = 16'h7FFF;
                1:       rx = 16'h8000;
                default: rx = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       ry = 16'hFFFF;
                1:       ry = 16'h8000;
                default: ry = 16'($urandom);
            endcase
            rs = 1'($urandom);
            want = model_op(rx, ry, rs);
            do_op(rx, ry, rs, $urandom_range(0, 3), got, lat);
            chk("rand_op", {13'd0, got}, {13'd0, want});
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
